// File: rtl/conv_out_pack.sv
// Requantizes 32-bit conv results to 8-bit lanes, packs eight per 64-bit word,
// and queues words in a first-word-fall-through FIFO with a registered head.
module conv_out_pack #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   in_data,
  input  logic                          in_valid,
  input  logic                          flush,
  input  logic [15:0]                   q_mult,
  input  logic [4:0]                    q_shift,
  input  logic                          relu_en,
  input  logic                          out_signed,
  output logic [63:0]                   m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_ovf,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, PUSH} flush_state_e;

  logic               s1_v_q, s1_v_d, s1_t_q, s1_t_d;
  logic               s2_v_q, s2_v_d, s2_t_q, s2_t_d;
  logic               s3_v_q, s3_v_d, s3_t_d;
  logic signed [47:0] p_q, p_d, r_q, r_d;
  logic [7:0]         b_q, b_d;
  logic [48:0]        prod;
  logic signed [47:0] rnd, sum, clip;
  logic               pre_left;

  logic [2:0]         cnt_q, cnt_d;
  logic [63:0]        lanes_q, lanes_d;
  logic               pw_v_q, pw_v_d;
  logic [63:0]        pw_q, pw_d;
  flush_state_e       state_q, state_d;

  logic [63:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0]      count_q, count_d;
  logic               out_v_q, out_v_d;
  logic [63:0]        out_q, out_d;
  logic               ovf_q, ovf_d, busy_q, busy_d;
  logic               pop, full, push_ok, ovf_set, mem_zero, mem_we;

  // Tags mark beats that belong to the word being flushed; while IDLE every beat does.
  always_comb begin
    prod   = {{17{in_data[31]}}, in_data} * {33'd0, q_mult};
    p_d    = prod[47:0];
    rnd    = (q_shift != 5'd0) ? (48'sd1 <<< (q_shift - 5'd1)) : 48'sd0;
    sum    = p_q + rnd;
    r_d    = sum >>> q_shift;
    clip   = (relu_en && r_q < 48'sd0) ? 48'sd0 : r_q;
    if (out_signed)
      b_d = (clip > 48'sd127) ? 8'h7F : (clip < -48'sd128) ? 8'h80 : clip[7:0];
    else
      b_d = (clip < 48'sd0) ? 8'h00 : (clip > 48'sd255) ? 8'hFF : clip[7:0];
    s1_v_d   = in_valid;
    s1_t_d   = in_valid && (state_q == IDLE);
    s2_v_d   = s1_v_q;
    s2_t_d   = s1_v_q && (s1_t_q || state_q == IDLE);
    s3_v_d   = s2_v_q;
    s3_t_d   = s2_v_q && (s2_t_q || state_q == IDLE);
    pre_left = s1_t_d || s2_t_d || s3_t_d;
  end

  always_comb begin
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    pw_v_d  = 1'b0;
    pw_d    = pw_q;
    if (state_q == PUSH && cnt_q != 3'd0) begin
      pw_v_d  = 1'b1;
      pw_d    = lanes_q;
      lanes_d = '0;
      cnt_d   = 3'd0;
      if (s3_v_q) begin
        lanes_d[7:0] = b_q;
        cnt_d        = 3'd1;
      end
    end else if (s3_v_q) begin
      lanes_d[{cnt_q, 3'b000} +: 8] = b_q;
      if (cnt_q == 3'd7) begin
        pw_v_d  = 1'b1;
        pw_d    = lanes_d;
        lanes_d = '0;
        cnt_d   = 3'd0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  // DRAIN leaves on the edge that writes the last tagged byte, so later beats start a fresh word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush) state_d = DRAIN;
      DRAIN:   if (!pre_left) state_d = (cnt_d != 3'd0) ? PUSH : IDLE;
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop      = out_v_q && m_ready;
    full     = (count_q == LW'(FIFO_DEPTH));
    push_ok  = pw_v_q && (!full || pop);
    ovf_set  = pw_v_q && full && !pop;
    mem_zero = (count_q == LW'(out_v_q));
    out_v_d  = out_v_q;
    out_d    = out_q;
    rd_d     = rd_q;
    mem_we   = 1'b0;
    if (!out_v_q || pop) begin
      if (!mem_zero) begin
        out_v_d = 1'b1;
        out_d   = mem[rd_q];
        rd_d    = rd_q + AW'(1);
        mem_we  = push_ok;
      end else if (push_ok) begin
        out_v_d = 1'b1;
        out_d   = pw_q;
      end else begin
        out_v_d = 1'b0;
      end
    end else begin
      mem_we = push_ok;
    end
    wr_d    = mem_we ? wr_q + AW'(1) : wr_q;
    count_d = count_q + LW'(push_ok) - LW'(pop);
    ovf_d   = ovf_set || (ovf_q && !clr_ovf);
    busy_d  = s1_v_d || s2_v_d || s3_v_d || pw_v_d || (cnt_d != 3'd0) || (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      s1_t_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      s2_t_q  <= 1'b0;
      s3_v_q  <= 1'b0;
      cnt_q   <= 3'd0;
      lanes_q <= '0;
      pw_v_q  <= 1'b0;
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      out_v_q <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_v_q  <= s1_v_d;
      s1_t_q  <= s1_t_d;
      s2_v_q  <= s2_v_d;
      s2_t_q  <= s2_t_d;
      s3_v_q  <= s3_v_d;
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
      pw_v_q  <= pw_v_d;
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      out_v_q <= out_v_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  // Datapath registers stay unreset so the multiply can map onto DSP blocks.
  always_ff @(posedge clk) begin
    p_q  <= p_d;
    r_q  <= r_d;
    b_q  <= b_d;
    pw_q <= pw_d;
    if (mem_we) mem[wr_q] <= pw_q;
  end

  assign m_data     = out_q;
  assign m_valid    = out_v_q;
  assign fifo_level = count_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;

endmodule
